// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the multi-ported register file.
package regfile_pkg;

   localparam int unsigned RF_ADDR_WIDTH = 5;
   localparam int unsigned RF_DATA_WIDTH = 32;
   localparam int unsigned RF_NUM_RD     = 2;
   localparam int unsigned RF_NUM_WR     = 2;
   localparam int unsigned RF_BYPASS     = 1;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_e;

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-index write winner: for every register index, reports whether any enabled
// write port targets it and the data of the highest-numbered such port.
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
   parameter int unsigned NUM_WR     = RF_NUM_WR
) (
   input  logic [NUM_WR-1:0]                              i_wr_en,
   input  logic [NUM_WR*ADDR_WIDTH-1:0]                   i_wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0]                   i_wr_data,
   output logic [2**ADDR_WIDTH-1:0]                       o_win_hit,
   output logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]       o_win_data
);

   // Walk ports low to high so a later (higher) port overwrites an earlier match.
   always_comb begin : p_arb
      o_win_hit  = '0;
      o_win_data = '0;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         if (i_wr_en[p]) begin
            o_win_hit[i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]]  = 1'b1;
            o_win_data[i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = i_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with pending-write scoreboard and a sequential
// zeroing sweep that runs after reset or on request.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
   parameter int unsigned NUM_RD     = RF_NUM_RD,
   parameter int unsigned NUM_WR     = RF_NUM_WR,
   parameter int unsigned BYPASS     = RF_BYPASS
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]    rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
   output logic [NUM_RD-1:0]               rd_busy,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR*ADDR_WIDTH-1:0]    wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
   input  logic                            issue_en,
   input  logic [ADDR_WIDTH-1:0]           issue_rd,
   input  logic                            clear_req,
   output logic                            ready,
   output logic [2**ADDR_WIDTH-1:0]        busy_vec
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;

   rf_state_e                          r_state;
   logic [ADDR_WIDTH-1:0]              r_clr_ptr;
   logic [DEPTH-1:0]                   r_busy;
   logic                               r_ready;
   logic [DEPTH-1:0]                   w_busy_nxt;
   logic                               w_wr_ok;
   logic [NUM_WR-1:0]                  w_wr_en_ok;
   logic [DEPTH-1:0]                   w_win_hit;
   logic [DEPTH-1:0][DATA_WIDTH-1:0]   w_win_data;
   logic [DATA_WIDTH-1:0]              w_mem [DEPTH];

   // Writes are accepted only in READY and not in a cycle that requests a clear.
   assign w_wr_ok    = (r_state == READY) && !clear_req;
   assign w_wr_en_ok = w_wr_ok ? wr_en : '0;

   regfile_wr_arb #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WR     (NUM_WR)
   ) u_wr_arb (
      .i_wr_en    (w_wr_en_ok),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .o_win_hit  (w_win_hit),
      .o_win_data (w_win_data)
   );

   // Scoreboard next value: writebacks clear, then issue sets (issue wins).
   always_comb begin : p_busy_nxt
      w_busy_nxt = r_busy;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         if (wr_en[p]) begin
            w_busy_nxt[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
         end
      end
      if (issue_en && (issue_rd != '0)) begin
         w_busy_nxt[issue_rd] = 1'b1;
      end
   end

   // Control FSM: sweep pointer, scoreboard and ready flag.
   always_ff @(posedge clk or negedge rst_n) begin : p_fsm
      if (!rst_n) begin
         r_state   <= CLEAR;
         r_clr_ptr <= '0;
         r_busy    <= '0;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
               if (r_clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                  r_state <= READY;
                  r_ready <= 1'b1;
               end
            end
            READY: begin
               if (clear_req) begin
                  r_state   <= CLEAR;
                  r_clr_ptr <= '0;
                  r_busy    <= '0;
                  r_ready   <= 1'b0;
               end else begin
                  r_busy <= w_busy_nxt;
               end
            end
            default: begin
               r_state   <= CLEAR;
               r_clr_ptr <= '0;
               r_busy    <= '0;
               r_ready   <= 1'b0;
            end
         endcase
      end
   end

   // Index 0 has no storage; it always reads zero.
   assign w_mem[0] = '0;

   for (genvar gi = 1; gi < DEPTH; gi++) begin : g_ent
      logic [DATA_WIDTH-1:0] r_q;

      // Entry storage: zeroed when the sweep reaches it, else takes the winning write.
      always_ff @(posedge clk) begin : p_ent
         if (r_state == CLEAR) begin
            if (r_clr_ptr == ADDR_WIDTH'(gi)) begin
               r_q <= '0;
            end
         end else if (w_win_hit[gi]) begin
            r_q <= w_win_data[gi];
         end
      end

      assign w_mem[gi] = r_q;
   end

   // Combinational read ports with optional same-cycle forwarding.
   always_comb begin : p_read
      logic [ADDR_WIDTH-1:0] v_idx;
      v_idx   = '0;
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         v_idx = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
         if (r_state == READY) begin
            rd_busy[k] = r_busy[v_idx];
            if (v_idx != '0) begin
               if ((BYPASS != 0) && w_win_hit[v_idx]) begin
                  rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_win_data[v_idx];
               end else begin
                  rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_mem[v_idx];
               end
            end
         end
      end
   end

   assign ready    = r_ready;
   assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp against a behavioural model, plus directed
// scenarios with literal expectations.
module tb_regfile_mp;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NR    = 2;
   localparam int NW    = 2;
   localparam int DEPTH = 32;

   logic                clk;
   logic                rst_n;
   logic [NR*AW-1:0]    rd_addr;
   logic [NR*DW-1:0]    rd_data;
   logic [NR-1:0]       rd_busy;
   logic [NW-1:0]       wr_en;
   logic [NW*AW-1:0]    wr_addr;
   logic [NW*DW-1:0]    wr_data;
   logic                issue_en;
   logic [AW-1:0]       issue_rd;
   logic                clear_req;
   logic                ready;
   logic [DEPTH-1:0]    busy_vec;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [DW-1:0]    mem_m [DEPTH];
   logic [DEPTH-1:0] busy_m;
   bit               ready_m;
   int               sweep_pos;

   regfile_mp #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_RD     (NR),
      .NUM_WR     (NW),
      .BYPASS     (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .issue_en  (issue_en),
      .issue_rd  (issue_rd),
      .clear_req (clear_req),
      .ready     (ready),
      .busy_vec  (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      wr_en     = '0;
      wr_addr   = '0;
      wr_data   = '0;
      issue_en  = 1'b0;
      issue_rd  = '0;
      clear_req = 1'b0;
      rd_addr   = '0;
   endtask

   task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
      wr_en[p]            = 1'b1;
      wr_addr[p*AW +: AW] = AW'(a);
      wr_data[p*DW +: DW] = d;
   endtask

   task automatic set_rd(input int k, input int a);
      rd_addr[k*AW +: AW] = AW'(a);
   endtask

   task automatic rand_inputs(input bit allow_clear);
      int unsigned a;
      for (int p = 0; p < NW; p++) begin
         wr_en[p] = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1);
         wr_addr[p*AW +: AW] = AW'(a);
         wr_data[p*DW +: DW] = $urandom();
      end
      issue_en = ($urandom_range(0, 2) == 0);
      issue_rd = AW'($urandom_range(0, 7));
      for (int k = 0; k < NR; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            a = $urandom_range(0, NW-1);
            rd_addr[k*AW +: AW] = wr_addr[a*AW +: AW];
         end else begin
            rd_addr[k*AW +: AW] = AW'($urandom_range(0, DEPTH-1));
         end
      end
      clear_req = allow_clear && ($urandom_range(0, 63) == 0);
      if (clear_req) wr_en = '0;
   endtask

   // Compare every DUT output against what the model says it must be now.
   task automatic model_check();
      int a;
      logic [DW-1:0] exp_d;
      logic exp_b;
      if (!rst_n) begin
         ready_m   = 1'b0;
         sweep_pos = 0;
         busy_m    = '0;
      end
      check("ready", 64'(ready), 64'(ready_m));
      check("busy_vec", 64'(busy_vec), 64'(busy_m));
      for (int k = 0; k < NR; k++) begin
         a = int'(rd_addr[k*AW +: AW]);
         exp_d = '0;
         exp_b = 1'b0;
         if (ready_m) begin
            exp_b = busy_m[a];
            if (a != 0) begin
               exp_d = mem_m[a];
               if (!clear_req) begin
                  for (int p = 0; p < NW; p++) begin
                     if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) exp_d = wr_data[p*DW +: DW];
                  end
               end
            end
         end
         check($sformatf("rd_data[%0d] x%0d", k, a), 64'(rd_data[k*DW +: DW]), 64'(exp_d));
         check($sformatf("rd_busy[%0d] x%0d", k, a), 64'(rd_busy[k]), 64'(exp_b));
      end
   endtask

   // Apply the effect of one rising edge to the model.
   task automatic model_update();
      int a;
      if (!rst_n) begin
         ready_m   = 1'b0;
         sweep_pos = 0;
         busy_m    = '0;
      end else if (!ready_m) begin
         mem_m[sweep_pos] = '0;
         sweep_pos++;
         if (sweep_pos == DEPTH) ready_m = 1'b1;
      end else if (clear_req) begin
         ready_m   = 1'b0;
         sweep_pos = 0;
         busy_m    = '0;
      end else begin
         for (int p = 0; p < NW; p++) begin
            if (wr_en[p]) begin
               a = int'(wr_addr[p*AW +: AW]);
               if (a != 0) mem_m[a] = wr_data[p*DW +: DW];
               busy_m[a] = 1'b0;
            end
         end
         if (issue_en && issue_rd != '0) busy_m[issue_rd] = 1'b1;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // Count sampled cycles with ready low until it rises (bounded).
   task automatic count_not_ready(input bit rnd, output int cnt);
      bit seen;
      seen = 1'b0;
      cnt  = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         sample();
         if (ready === 1'b1) begin
            seen = 1'b1;
         end else begin
            cnt++;
            if (rnd) rand_inputs(1'b0);
            advance();
         end
      end
      if (!seen) check("ready rise timeout", 64'(0), 64'(1));
   endtask

   initial begin
      int cnt;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      busy_m    = '0;
      ready_m   = 1'b0;
      sweep_pos = 0;
      rst_n     = 1'b0;
      idle();

      // Reset held, then initial sweep
      repeat (3) begin sample(); advance(); end
      rst_n = 1'b1;
      count_not_ready(1'b0, cnt);
      check("initial sweep length", 64'(cnt), 64'(32));
      advance();

      // All entries read zero after the sweep
      for (int i = 0; i < DEPTH; i++) begin
         idle();
         set_rd(0, i);
         set_rd(1, DEPTH-1-i);
         sample();
         check($sformatf("post-sweep x%0d", i), 64'(rd_data[DW-1:0]), 64'(0));
         check($sformatf("post-sweep x%0d", DEPTH-1-i), 64'(rd_data[2*DW-1:DW]), 64'(0));
         advance();
      end
      check("post-sweep busy_vec", 64'(busy_vec), 64'(0));

      // Same-index dual write: highest port wins, forwarded same cycle
      idle();
      set_wr(0, 5, 32'hAAAA_0001);
      set_wr(1, 5, 32'h5555_0002);
      set_rd(0, 5);
      sample();
      check("x5 bypass", 64'(rd_data[DW-1:0]), 64'h5555_0002);
      advance();
      idle();
      set_rd(0, 5);
      sample();
      check("x5 committed", 64'(rd_data[DW-1:0]), 64'h5555_0002);
      advance();

      // Index 0 write and issue are discarded
      idle();
      set_wr(0, 0, 32'hFFFF_FFFF);
      issue_en = 1'b1;
      issue_rd = '0;
      set_rd(0, 0);
      sample();
      check("x0 same-cycle", 64'(rd_data[DW-1:0]), 64'(0));
      advance();
      idle();
      set_rd(0, 0);
      sample();
      check("x0 read", 64'(rd_data[DW-1:0]), 64'(0));
      check("x0 busy", 64'(busy_vec[0]), 64'(0));
      advance();

      // Scoreboard: issue, issue+writeback, writeback alone
      idle();
      set_rd(0, 7);
      issue_en = 1'b1;
      issue_rd = AW'(7);
      sample();
      check("x7 busy before issue", 64'(rd_busy[0]), 64'(0));
      advance();
      idle();
      set_rd(0, 7);
      sample();
      check("x7 busy after issue", 64'(rd_busy[0]), 64'(1));
      advance();
      idle();
      set_rd(0, 7);
      set_wr(0, 7, 32'h0000_0777);
      issue_en = 1'b1;
      issue_rd = AW'(7);
      sample();
      advance();
      idle();
      set_rd(0, 7);
      sample();
      check("x7 busy issue wins", 64'(rd_busy[0]), 64'(1));
      advance();
      idle();
      set_rd(0, 7);
      set_wr(1, 7, 32'h0000_0778);
      sample();
      advance();
      idle();
      set_rd(0, 7);
      sample();
      check("x7 busy after writeback", 64'(rd_busy[0]), 64'(0));
      check("x7 data", 64'(rd_data[DW-1:0]), 64'h0000_0778);
      advance();

      // Clear request: sweep length, writes during sweep ignored, x3 zeroed
      idle();
      set_wr(0, 3, 32'h0000_1234);
      sample();
      advance();
      idle();
      set_rd(0, 3);
      sample();
      check("x3 before clear", 64'(rd_data[DW-1:0]), 64'h0000_1234);
      advance();
      idle();
      clear_req = 1'b1;
      sample();
      advance();
      idle();
      count_not_ready(1'b1, cnt);
      check("clear sweep length", 64'(cnt), 64'(32));
      idle();
      advance();
      idle();
      set_rd(0, 3);
      set_rd(1, 5);
      sample();
      check("x3 after clear", 64'(rd_data[DW-1:0]), 64'(0));
      check("x5 after clear", 64'(rd_data[2*DW-1:DW]), 64'(0));
      advance();

      // Reset mid-sweep restarts the sweep from entry 0
      idle();
      clear_req = 1'b1;
      sample();
      advance();
      idle();
      repeat (10) begin sample(); advance(); end
      rst_n = 1'b0;
      repeat (3) begin sample(); advance(); end
      check("ready during reset", 64'(ready), 64'(0));
      rst_n = 1'b1;
      count_not_ready(1'b0, cnt);
      check("restarted sweep length", 64'(cnt), 64'(32));
      advance();

      // Randomized traffic checked every cycle by the model
      for (int i = 0; i < 1500; i++) begin
         rand_inputs(1'b1);
         sample();
         advance();
      end
      idle();
      sample();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the register index width; depth is 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the register data width.
REQ-003 Parameter NUM_RD, default 2, SHALL set the number of read ports.
REQ-004 Parameter NUM_WR, default 2, SHALL set the number of write ports.
REQ-005 Parameter BYPASS, default 1, SHALL enable same-cycle write-to-read forwarding when 1.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 rd_addr  in  NUM_RD*ADDR_WIDTH  packed read indices; port k occupies slice k.
REQ-009 rd_data  out  NUM_RD*DATA_WIDTH  packed read data; port k occupies slice k.
REQ-010 rd_busy  out  NUM_RD  scoreboard busy bit of each read index.
REQ-011 wr_en  in  NUM_WR  per-port write enable.
REQ-012 wr_addr  in  NUM_WR*ADDR_WIDTH  packed write indices.
REQ-013 wr_data  in  NUM_WR*DATA_WIDTH  packed write data.
REQ-014 issue_en  in  1  marks issue_rd as pending-write (busy).
REQ-015 issue_rd  in  ADDR_WIDTH  index to mark busy.
REQ-016 clear_req  in  1  one-cycle request to re-zero the array and scoreboard.
REQ-017 ready  out  1  high when the array is usable (state READY).
REQ-018 busy_vec  out  2**ADDR_WIDTH  full scoreboard.

Function
REQ-019 FSM states SHALL be CLEAR and READY only.
REQ-020 CLEAR: each cycle write 0 to entry clr_ptr, clr_ptr+1; after entry 2**ADDR_WIDTH-1 SHALL go to READY next cycle (depth cycles total).
REQ-021 READY with clear_req=1 SHALL go to CLEAR with clr_ptr=0 and all busy bits cleared next edge; same-cycle writes and issue SHALL be dropped.
REQ-022 clear_req during CLEAR SHALL be ignored (sweep not restarted).
REQ-023 In CLEAR: ready=0, rd_data=0, rd_busy=0, wr_en and issue_en ignored.
REQ-024 Reads SHALL be combinational; index 0 SHALL always read 0.
REQ-025 Writes SHALL commit on the rising edge; writes to index 0 SHALL be discarded.
REQ-026 Multiple enabled write ports to the same index SHALL commit the highest-numbered port's data.
REQ-027 BYPASS=1: rd_data SHALL return the same-cycle winning write data for a matching nonzero index; BYPASS=0: old contents until next cycle.
REQ-028 issue_en SHALL set busy[issue_rd] on the next edge; issue_rd=0 SHALL never set busy.
REQ-029 Each enabled write port SHALL clear busy[wr_addr] on the next edge.
REQ-030 Issue and writeback to the same index in one cycle SHALL leave busy set (issue wins).
REQ-031 rd_busy[k] SHALL equal busy_vec[rd_addr slice k], without bypass of same-cycle issue/clear.

Reset
REQ-032 rst_n low SHALL immediately force state CLEAR, clr_ptr=0, busy_vec=0, ready=0.
REQ-033 Array contents SHALL NOT be async reset; zeroing SHALL occur via the CLEAR sweep after rst_n rises.
REQ-034 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from entry 0 on release.

Structure
REQ-035 Shared package regfile_pkg SHALL hold the state enum (CLEAR, READY) and default parameter constants.
REQ-036 One sub-module regfile_wr_arb SHALL resolve per-index write winner (highest port) and feed commit and bypass paths.
REQ-037 Target 120-400 lines of RTL; no vendor RAM primitives.

Verification
REQ-038 Release rst_n -> ready=0 for 32 cycles (defaults), then 1; all 32 reads return 0, busy_vec=0.
REQ-039 Port0 wr x5=0xAAAA_0001 and port1 wr x5=0x5555_0002 same cycle -> x5 reads 0x5555_0002; with BYPASS=1 same-cycle rd_data already 0x5555_0002.
REQ-040 Write x0=0xFFFF_FFFF, issue_rd=0 -> x0 reads 0, busy_vec[0]=0.
REQ-041 Issue x7, next cycle rd_busy for x7 =1; writeback x7 concurrently with issue x7 -> busy stays 1; writeback alone -> busy 0 next cycle.
REQ-042 Write x3=0x1234, pulse clear_req -> ready=0 for 32 cycles, writes during sweep ignored, x3 then reads 0.
REQ-043 Assert rst_n low at sweep entry 10 -> ready stays 0, sweep restarts, ready rises 32 cycles after release.
